prng_arbiter: RTL and testbench
===============================

PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 The block SHALL have parameter STEPS, default 8, meaning LFSR shifts per grant, legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 req  input  2  per-requester random-byte request, level, held until own gnt bit.
REQ-005 seed_load  input  1  load seed into LFSR, honoured in IDLE only.
REQ-006 seed  input  8  seed value for seed_load.
REQ-007 gnt  output  2  one-hot grant, high exactly one cycle, coincident with valid.
REQ-008 rnd  output  8  random byte, meaningful only while valid=1.
REQ-009 valid  output  1  rnd delivery strobe, one cycle.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL contain one 8-bit Fibonacci LFSR: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-012 The LFSR SHALL shift only in state RUN; it SHALL hold in IDLE and DELIVER.
REQ-013 FSM states SHALL be IDLE, RUN, DELIVER.
REQ-014 IDLE: seed_load=1 -> LFSR loads seed (see REQ-024), stay IDLE; else any req bit set -> latch winner, clear step counter, go RUN.
REQ-015 seed_load and req asserted together in IDLE: seed load wins; req is evaluated on the next IDLE cycle.
REQ-016 seed_load outside IDLE SHALL be ignored with no effect.
REQ-017 Arbitration SHALL be round-robin: one req -> that requester; both -> requester indicated by priority pointer; pointer moves to the other requester after each grant.
REQ-018 RUN: LFSR shifts every cycle; after STEPS shifts go DELIVER; the step counter SHALL be 4 bits.
REQ-019 DELIVER: valid=1, gnt=one-hot of latched winner, rnd=current LFSR; next state IDLE unconditionally.
REQ-020 Latency: req sampled at edge N -> valid/gnt high during cycle after edge N+STEPS+1; back-to-back grants separated by one IDLE cycle minimum.
REQ-021 A latched winner SHALL be granted even if its req drops during RUN; new req edges during RUN/DELIVER SHALL be ignored until IDLE.
REQ-022 gnt, valid SHALL be 0 outside DELIVER; rnd SHALL be 8'h00 outside DELIVER.

Reset
REQ-023 rst=1 SHALL immediately, mid-operation included, force: state IDLE, LFSR=8'h2A, step counter 0, priority pointer to requester 0, gnt=2'b00, valid=0, rnd=8'h00, busy=0; any in-flight request is discarded.

Configuration
REQ-024 Macro PRNG_ARB_ZERO_GUARD_EN: defined -> seed_load with seed=8'h00 loads 8'h2A instead; undefined -> seed loaded verbatim, so zero seed locks LFSR at 8'h00 and rnd=8'h00 thereafter until reseed/reset; all other behaviour identical.

Verification (STEPS=3 unless noted)
REQ-025 Reset, req=2'b01 for one cycle -> busy next cycle, gnt=2'b01, valid=1, rnd=8'h53 four cycles after request edge; busy low after.
REQ-026 After REQ-025, req=2'b10 -> gnt=2'b10, rnd=8'h9D.
REQ-027 Reset, req=2'b11 held -> grants in order 2'b01 (8'h53), 2'b10 (8'h9D), 2'b01, each valid pulse exactly one cycle.
REQ-028 In IDLE seed_load=1, seed=8'h01 together with req=2'b01 -> seed loaded first; grant to requester 0 with rnd=8'h08.
REQ-029 seed_load=1, seed=8'h00, then req=2'b01 -> with macro rnd=8'h53; without macro rnd=8'h00.
REQ-030 rst pulsed during RUN -> gnt, valid, busy low immediately; no grant delivered; next req=2'b10 gets rnd=8'h53.

Source files
------------

// File: rtl/prng_arbiter_if.sv
// Request/grant bundle for prng_arbiter: two requesters share one LFSR byte source.
// The master side drives requests and seeding; the slave side returns grants and random bytes.
interface prng_arbiter_if;
    logic [1:0] req;
    logic       seed_load;
    logic [7:0] seed;
    logic [1:0] gnt;
    logic [7:0] rnd;
    logic       valid;
    logic       busy;

    modport master (
        output req, seed_load, seed,
        input  gnt, rnd, valid, busy
    );

    modport slave (
        input  req, seed_load, seed,
        output gnt, rnd, valid, busy
    );
endinterface

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out LFSR bytes: each grant advances an 8-bit LFSR STEPS times.
// Optional macro PRNG_ARB_ZERO_GUARD_EN replaces a zero seed with the reset seed 8'h2A.
module prng_arbiter #(
    parameter int STEPS = 8
) (
    input logic           clk,
    input logic           rst,
    prng_arbiter_if.slave bus
);

    if (STEPS < 1 || STEPS > 15) begin : g_steps_check
        $error("prng_arbiter: STEPS must be in 1..15");
    end

    localparam logic [7:0] LFSR_INIT = 8'h2A;
    localparam logic [3:0] STEPS_CNT = 4'(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DELIVER
    } state_t;

    state_t     state, state_next;
    logic [7:0] lfsr, lfsr_next;
    logic [3:0] step_cnt, step_cnt_next;
    logic       winner, winner_next;
    logic       prio, prio_next;
    logic [7:0] seed_val;
    logic [7:0] lfsr_shift;
    logic       pick;

`ifdef PRNG_ARB_ZERO_GUARD_EN
    assign seed_val = (bus.seed == 8'h00) ? LFSR_INIT : bus.seed;
`else
    assign seed_val = bus.seed;
`endif

    assign lfsr_shift = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Single requester wins outright; a tie goes to the priority pointer.
    assign pick = (bus.req == 2'b11) ? prio : bus.req[1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= LFSR_INIT;
            step_cnt <= '0;
            winner   <= 1'b0;
            prio     <= 1'b0;
        end else begin
            state    <= state_next;
            lfsr     <= lfsr_next;
            step_cnt <= step_cnt_next;
            winner   <= winner_next;
            prio     <= prio_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        lfsr_next     = lfsr;
        step_cnt_next = step_cnt;
        winner_next   = winner;
        prio_next     = prio;
        unique case (state)
            IDLE: begin
                if (bus.seed_load) begin
                    lfsr_next = seed_val;
                end else if (|bus.req) begin
                    winner_next   = pick;
                    step_cnt_next = '0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                // The cycle that sees the full count hands over without shifting again,
                // giving exactly STEPS shifts and a STEPS+1 cycle RUN phase.
                if (step_cnt == STEPS_CNT) begin
                    state_next = DELIVER;
                end else begin
                    lfsr_next     = lfsr_shift;
                    step_cnt_next = step_cnt + 4'd1;
                end
            end
            DELIVER: begin
                prio_next  = ~winner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.valid = (state == DELIVER);
        bus.busy  = (state != IDLE);
        bus.gnt   = 2'b00;
        bus.rnd   = 8'h00;
        if (state == DELIVER) begin
            bus.gnt = winner ? 2'b10 : 2'b01;
            bus.rnd = lfsr;
        end
    end

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter (STEPS=3): expected grants go into a scoreboard queue
// as requests are driven and are popped by a monitor on every valid strobe.
module tb_prng_arbiter;

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] rnd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

`ifdef PRNG_ARB_ZERO_GUARD_EN
    localparam logic [7:0] ZERO_SEED_RND = 8'h53;
`else
    localparam logic [7:0] ZERO_SEED_RND = 8'h00;
`endif

    prng_arbiter_if bus ();

    prng_arbiter #(.STEPS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every valid cycle must match the oldest expected grant.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", {22'd0, bus.gnt, bus.rnd}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("grant", {22'd0, bus.gnt, bus.rnd}, {22'd0, e.gnt, e.rnd});
            end
        end else begin
            check("idle_outputs", {22'd0, bus.gnt, bus.rnd}, 32'h0);
        end
    end

    task automatic push(input logic [1:0] g, input logic [7:0] r);
        exp_t e;
        e.gnt = g;
        e.rnd = r;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Asynchronous reset pulse checked one time step after assertion.
    task automatic reset_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_outs", {20'd0, bus.gnt, bus.valid, bus.busy, bus.rnd}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.seed_load = 1'b0;
        bus.seed      = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;

        // Single request, exact latency: valid at the negedge after edge N+4.
        @(negedge clk);
        bus.req = 2'b01;
        push(2'b01, 8'h53);
        @(negedge clk);
        bus.req = 2'b00;
        check("busy_after_req", {31'd0, bus.busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("not_yet_valid", {30'd0, bus.valid, bus.busy}, 32'h1);
        @(negedge clk);
        check("valid_on_time", {31'd0, bus.valid}, 32'd1);
        @(negedge clk);
        check("busy_low_after", {30'd0, bus.valid, bus.busy}, 32'h0);
        check("sb_empty_1", sb_q.size(), 0);

        // Second requester continues the sequence.
        bus.req = 2'b10;
        push(2'b10, 8'h9D);
        @(negedge clk);
        bus.req = 2'b00;
        wait_drain(20);

        // Both held from reset: alternating grants.
        reset_pulse();
        bus.req = 2'b11;
        push(2'b01, 8'h53);
        push(2'b10, 8'h9D);
        push(2'b01, 8'hEE);
        wait_drain(40);
        bus.req = 2'b00;
        repeat (8) @(negedge clk);
        check("no_extra_grant", {31'd0, bus.busy}, 32'd0);

        // Seed load beats a simultaneous request.
        reset_pulse();
        bus.seed_load = 1'b1;
        bus.seed      = 8'h01;
        bus.req       = 2'b01;
        push(2'b01, 8'h08);
        @(negedge clk);
        check("seed_stays_idle", {31'd0, bus.busy}, 32'd0);
        bus.seed_load = 1'b0;
        @(negedge clk);
        bus.req = 2'b00;
        wait_drain(20);

        // Zero seed: guarded or locked depending on build.
        bus.seed_load = 1'b1;
        bus.seed      = 8'h00;
        @(negedge clk);
        bus.seed_load = 1'b0;
        bus.req       = 2'b01;
        push(2'b01, ZERO_SEED_RND);
        @(negedge clk);
        bus.req = 2'b00;
        wait_drain(20);

        // Reset during RUN discards the in-flight grant.
        reset_pulse();
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        @(negedge clk);
        check("busy_in_run", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst", {20'd0, bus.gnt, bus.valid, bus.busy, bus.rnd}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus.req = 2'b10;
        push(2'b10, 8'h53);
        @(negedge clk);
        bus.req = 2'b00;
        wait_drain(20);

        // Seed load during RUN has no effect; LFSR continues from 8'h53.
        bus.req = 2'b01;
        push(2'b01, 8'h9D);
        @(negedge clk);
        bus.req       = 2'b00;
        bus.seed_load = 1'b1;
        bus.seed      = 8'hFF;
        repeat (2) @(negedge clk);
        bus.seed_load = 1'b0;
        wait_drain(20);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
